// File: rtl/sram_pkg.sv
// Shared defaults and FSM encoding for the SRAM access controller.
package sram_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_e;
endpackage

// File: rtl/sram_wl_decoder.sv
// Address-to-word-line decoder; all lines low when disabled.
module sram_wl_decoder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  output logic [DEPTH-1:0]  wl_o
);
  always_comb begin
    wl_o = '0;
    if (en_i) wl_o[addr_i] = 1'b1;
  end
endmodule

// File: rtl/sram_access_ctrl.sv
// Single-port SRAM sequencer: setup / strobe / hold phases per access, read data held until consumed.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [DEPTH-1:0]        wl,
  output logic [DATA_W-1:0]       bl_data,
  output logic                    bl_oe,
  input  logic [DEPTH*DATA_W-1:0] arr_dout
);
  state_e                         state_q, state_d;
  logic                           we_q;
  logic [ADDR_W-1:0]              addr_q;
  logic [DATA_W-1:0]              wdata_q;
  logic [DEPTH-1:0]               wl_q, wl_d;
  logic                           bl_oe_q, bl_oe_d;
  logic [DATA_W-1:0]              bl_data_q, bl_data_d;
  logic [DATA_W-1:0]              rdata_q, rdata_d;
  logic [DEPTH-1:0][DATA_W-1:0]   words;
  logic                           accept;

  assign words     = arr_dout;
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = (state_q == IDLE) && req_valid;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign wl        = wl_q;
  assign bl_oe     = bl_oe_q;
  assign bl_data   = bl_data_q;

  // Decoding from SETUP makes the registered word line high in STROBE only.
  sram_wl_decoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dec (
    .addr_i (addr_q),
    .en_i   (state_q == SETUP),
    .wl_o   (wl_d)
  );

  always_comb begin
    state_d   = state_q;
    bl_oe_d   = bl_oe_q;
    bl_data_d = bl_data_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d   = SETUP;
        bl_oe_d   = req_we;
        bl_data_d = req_we ? req_wdata : '0;
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        bl_oe_d   = 1'b0;
        bl_data_d = '0;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
          rdata_d = words[addr_q];
        end
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wl_q      <= '0;
      bl_oe_q   <= 1'b0;
      bl_data_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wl_q      <= wl_d;
      bl_oe_q   <= bl_oe_d;
      bl_data_q <= bl_data_d;
      rdata_q   <= rdata_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^wdata_q;
endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of words, power of two.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have req_valid  input  1  request present.
REQ-007 SHALL have req_ready  output  1  controller accepts a request this cycle.
REQ-008 SHALL have req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have req_addr  input  ADDR_W  word address.
REQ-010 SHALL have req_wdata  input  DATA_W  write data.
REQ-011 SHALL have rsp_valid  output  1  read data valid.
REQ-012 SHALL have rsp_ready  input  1  consumer accepts read data.
REQ-013 SHALL have rsp_rdata  output  DATA_W  read data.
REQ-014 SHALL have wl  output  DEPTH  one-hot word lines to the array words.
REQ-015 SHALL have bl_data  output  DATA_W  data driven to all array words.
REQ-016 SHALL have bl_oe  output  1  1 = bl_data driven (write); 0 = bit lines released (read).
REQ-017 SHALL have arr_dout  input  DEPTH*DATA_W  flattened per-word outputs, word k at bits [k*DATA_W +: DATA_W]; each word captures its cell data on the rising edge of its word line.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD, RESP.
REQ-019 SHALL assert req_ready only in IDLE; a handshake is req_valid & req_ready at a rising edge.
REQ-020 SHALL, on handshake at edge T, register req_we, req_addr, req_wdata and enter SETUP; later changes to the req_* inputs SHALL have no effect until the next handshake.
REQ-021 SETUP (cycle after T): wl all zero; bl_oe = latched we; bl_data = latched wdata for writes, zero for reads.
REQ-022 STROBE (T+2): wl[latched addr] = 1, all other bits 0; bl_oe and bl_data held.
REQ-023 HOLD (T+3): wl all zero; bl_oe and bl_data held; read SHALL capture arr_dout word [latched addr] into rsp_rdata at the end of HOLD.
REQ-024 After HOLD: a write SHALL return to IDLE (req_ready high at T+4) and produce no response; a read SHALL enter RESP (rsp_valid high at T+4).
REQ-025 RESP: rsp_valid = 1, rsp_rdata stable; exit to IDLE on the edge where rsp_ready = 1; SHALL hold indefinitely while rsp_ready = 0.
REQ-026 wl SHALL be at most one-hot in every cycle and high for exactly one cycle per accepted request.
REQ-027 bl_oe SHALL be 0 outside SETUP/STROBE/HOLD of a write; bl_data SHALL be zero whenever bl_oe = 0.
REQ-028 All addresses 0..DEPTH-1 are valid; address DEPTH-1 and 0 SHALL behave identically to interior addresses.
REQ-029 Requests arriving while req_ready = 0 SHALL not be accepted or queued; the requester holds them.

Reset
REQ-030 On an edge with rst = 1, state SHALL become IDLE; wl = 0, bl_oe = 0, bl_data = 0, rsp_valid = 0, rsp_rdata = 0, latched request = 0.
REQ-031 Reset in any state (including STROBE) SHALL drop the in-flight request: no further wl pulse and no response; req_ready SHALL be 0 while rst = 1 and 1 in the first cycle after rst is released.

Structure
REQ-032 Package sram_pkg SHALL hold DATA_W, DEPTH, ADDR_W defaults and the FSM state enum.
REQ-033 Sub-module sram_wl_decoder SHALL convert (addr, enable) to the one-hot wl vector; the controller SHALL register its output.

Verification
REQ-034 Write addr 3, data 0xDEADBEEF, handshake at T -> wl = 0x0008 only at T+2; bl_oe = 1 and bl_data = 0xDEADBEEF over T+1..T+3; req_ready high at T+4; no rsp_valid.
REQ-035 Read addr 3, arr_dout word 3 = 0xDEADBEEF -> bl_oe = 0 throughout; rsp_valid at T+4 with rsp_rdata = 0xDEADBEEF.
REQ-036 Read addr 15 with rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable; req_ready = 0; one cycle after rsp_ready rises, req_ready = 1.
REQ-037 rst asserted during STROBE -> next cycle wl = 0, bl_oe = 0, rsp_valid = 0; no later wl pulse or response.
REQ-038 Back-to-back writes to addr 0 and addr 15 with req_valid held high -> second handshake at T+4; wl pulses 0x0001 at T+2 and 0x8000 at T+6; never two wl bits high.
